// File: rtl/text_scroll_window.sv
// Captures a text message into a buffer and presents it on the 16-character
// display, either statically or as a left-scrolling, wrapping window.
module text_scroll_window #(
    parameter int BUF_DEPTH   = 64,
    parameter int WINDOW      = 16,
    parameter int GAP         = 4,
    parameter int STEP_CYCLES = 6750000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_start,
    input  logic [7:0]            char_in,
    input  logic                  char_valid,
    input  logic                  load_done,
    input  logic                  freeze,
    output logic [8*WINDOW-1:0]   window,
    output logic [6:0]            msg_len,
    output logic                  busy,
    output logic                  overflow,
    output logic                  scroll_tick
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int SW = $clog2(STEP_CYCLES);
    localparam int FW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    localparam logic [6:0]          DEPTH_LEN = 7'(BUF_DEPTH);
    localparam logic [6:0]          WIN_LEN   = 7'(WINDOW);
    localparam logic [6:0]          GAP_LEN   = 7'(GAP);
    localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [FW-1:0]       FILL_LAST = FW'(WINDOW - 1);
    localparam logic [8*WINDOW-1:0] BLANK     = {WINDOW{8'h20}};

    typedef enum logic [2:0] {IDLE, LOAD, FILL, SHOW, SCROLL} state_t;

    state_t              state, state_next;
    logic [7:0]          msg_buf [BUF_DEPTH];
    logic [6:0]          msg_len_next, len_cap;
    logic [6:0]          rd_idx, rd_idx_next, scroll_last;
    logic [SW-1:0]       step_cnt, step_next;
    logic [FW-1:0]       fill_cnt, fill_next;
    logic [8*WINDOW-1:0] window_next;
    logic                armed, armed_next;
    logic                overflow_next, tick_next;
    logic                wr_en;
    logic [7:0]          seq_char;

    // Positions past the captured message read as blanks, which also forms the gap.
    assign seq_char    = (rd_idx < msg_len) ? msg_buf[rd_idx[AW-1:0]] : 8'h20;
    assign scroll_last = msg_len + GAP_LEN - 7'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            window      <= BLANK;
            msg_len     <= 7'd0;
            overflow    <= 1'b0;
            scroll_tick <= 1'b0;
            armed       <= 1'b0;
            rd_idx      <= 7'd0;
            step_cnt    <= '0;
            fill_cnt    <= '0;
        end else begin
            state       <= state_next;
            window      <= window_next;
            msg_len     <= msg_len_next;
            overflow    <= overflow_next;
            scroll_tick <= tick_next;
            armed       <= armed_next;
            rd_idx      <= rd_idx_next;
            step_cnt    <= step_next;
            fill_cnt    <= fill_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            msg_buf[msg_len[AW-1:0]] <= char_in;
        end
    end

    always_comb begin
        state_next    = state;
        window_next   = window;
        msg_len_next  = msg_len;
        overflow_next = overflow;
        tick_next     = 1'b0;
        armed_next    = armed;
        rd_idx_next   = rd_idx;
        step_next     = step_cnt;
        fill_next     = fill_cnt;
        wr_en         = 1'b0;
        len_cap       = msg_len;
        busy          = (state == LOAD) || (state == FILL);

        if (load_start) begin
            state_next    = LOAD;
            msg_len_next  = 7'd0;
            overflow_next = 1'b0;
            armed_next    = 1'b0;
            window_next   = BLANK;
        end else begin
            case (state)
                LOAD: begin
                    if (char_valid) begin
                        if (msg_len < DEPTH_LEN) begin
                            wr_en   = 1'b1;
                            len_cap = msg_len + 7'd1;
                        end else begin
                            overflow_next = 1'b1;
                        end
                    end
                    msg_len_next = len_cap;
                    if (!load_done) begin
                        armed_next = 1'b1;
                    end
                    // A done level left over from the previous message must not end this load.
                    if (armed && load_done) begin
                        if (len_cap == 7'd0) begin
                            state_next = IDLE;
                        end else begin
                            state_next  = FILL;
                            rd_idx_next = 7'd0;
                            fill_next   = '0;
                        end
                    end
                end
                FILL: begin
                    window_next = {window[8*WINDOW-9:0], seq_char};
                    rd_idx_next = rd_idx + 7'd1;
                    fill_next   = fill_cnt + FW'(1);
                    if (fill_cnt == FILL_LAST) begin
                        if (msg_len <= WIN_LEN) begin
                            state_next = SHOW;
                        end else begin
                            state_next  = SCROLL;
                            rd_idx_next = WIN_LEN;
                            step_next   = '0;
                        end
                    end
                end
                SCROLL: begin
                    if (!freeze) begin
                        if (step_cnt == STEP_LAST) begin
                            step_next   = '0;
                            tick_next   = 1'b1;
                            window_next = {window[8*WINDOW-9:0], seq_char};
                            rd_idx_next = (rd_idx == scroll_last) ? 7'd0 : rd_idx + 7'd1;
                        end else begin
                            step_next = step_cnt + SW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_text_scroll_window.sv
// Self-checking bench for text_scroll_window: random messages compared
// against a sequence-level model of the expected display window.
module tb_text_scroll_window;
    localparam int WINDOW = 16;
    localparam int GAP    = 4;
    localparam int DEPTH  = 64;
    localparam int STEP   = 4;
    localparam logic [127:0] BLANK = {16{8'h20}};

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         load_start = 1'b0;
    logic [7:0]   char_in = 8'h00;
    logic         char_valid = 1'b0;
    logic         load_done = 1'b1;
    logic         freeze = 1'b0;
    logic [127:0] window;
    logic [6:0]   msg_len;
    logic         busy;
    logic         overflow;
    logic         scroll_tick;

    int total = 0;
    int passed = 0;
    int failed = 0;

    logic [7:0] gen_msg   [128];
    logic [7:0] model_msg [128];
    int         model_len = 0;
    bit         model_ovf = 1'b0;

    text_scroll_window #(
        .BUF_DEPTH(DEPTH), .WINDOW(WINDOW), .GAP(GAP), .STEP_CYCLES(STEP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .load_start(load_start), .char_in(char_in),
        .char_valid(char_valid), .load_done(load_done), .freeze(freeze),
        .window(window), .msg_len(msg_len), .busy(busy), .overflow(overflow),
        .scroll_tick(scroll_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Window as defined by the message sequence: seq[k] = message char or blank.
    function automatic logic [127:0] exp_window(input int ticks);
        logic [127:0] w;
        int len_l;
        int k;
        w = '0;
        len_l = model_len + GAP;
        for (int i = 0; i < WINDOW; i++) begin
            k = (model_len <= WINDOW) ? i : (ticks + i) % len_l;
            w[127-8*i -: 8] = (k < model_len) ? model_msg[k] : 8'h20;
        end
        return w;
    endfunction

    function automatic int set_text(input string s);
        for (int i = 0; i < s.len(); i++) gen_msg[i] = s[i];
        return s.len();
    endfunction

    function automatic int set_random(input int n);
        for (int i = 0; i < n; i++) gen_msg[i] = 8'($urandom_range(33, 126));
        return n;
    endfunction

    // Runs one full load; returns just after the edge that leaves LOAD.
    task automatic apply_stimulus(input int n, input bit done_with_last, input bit gaps);
        bit same;
        same = done_with_last && (n > 0);
        load_start = 1'b1;
        load_done  = 1'b0;
        char_valid = 1'b0;
        step();
        load_start = 1'b0;
        step();
        for (int i = 0; i < n; i++) begin
            char_in    = gen_msg[i];
            char_valid = 1'b1;
            if (same && i == n - 1) load_done = 1'b1;
            step();
            char_valid = 1'b0;
            if (gaps && i < n - 1 && $urandom_range(0, 3) == 0) step();
        end
        if (!same) begin
            load_done = 1'b1;
            step();
        end
        model_len = (n < DEPTH) ? n : DEPTH;
        model_ovf = (n > DEPTH);
        for (int i = 0; i < model_len; i++) model_msg[i] = gen_msg[i];
    endtask

    task automatic fill_and_check(input string tag);
        check_output({tag, "_busy_fill"}, 128'(busy), 128'(model_len > 0));
        repeat (WINDOW) step();
        check_output({tag, "_window"}, window, exp_window(0));
        check_output({tag, "_len"}, 128'(msg_len), 128'(model_len));
        check_output({tag, "_ovf"}, 128'(overflow), 128'(model_ovf));
        check_output({tag, "_busy_done"}, 128'(busy), 128'(0));
    endtask

    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!scroll_tick && cycles < 200);
    endtask

    task automatic scroll_check(input string tag, input int nticks);
        int c;
        logic [127:0] lit;
        for (int t = 1; t <= nticks; t++) begin
            wait_tick(c);
            check_output($sformatf("%s_spacing%0d", tag, t), 128'(c), 128'(STEP));
            check_output($sformatf("%s_win%0d", tag, t), window, exp_window(t));
            if (tag == "abc") begin
                lit = "BCDEFGHIJKLMNOPQ";
                if (t == 1) check_output("abc_lit1", window, lit);
                lit = "FGHIJKLMNOPQRST ";
                if (t == 5) check_output("abc_lit5", window, lit);
                lit = "ABCDEFGHIJKLMNOP";
                if (t == 24) check_output("abc_lit24", window, lit);
            end
        end
    endtask

    initial begin
        int n;
        int c;
        int ticks_seen;
        logic [127:0] lit;
        logic [127:0] held;

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        check_output("rst_window", window, BLANK);
        check_output("rst_len", 128'(msg_len), 128'(0));
        check_output("rst_busy", 128'(busy), 128'(0));
        check_output("rst_ovf", 128'(overflow), 128'(0));
        check_output("rst_tick", 128'(scroll_tick), 128'(0));
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        step();

        // Short message stays static; stray characters outside LOAD are ignored
        n = set_text("HELLO");
        apply_stimulus(n, 1'b0, 1'b0);
        fill_and_check("hello");
        lit = "HELLO           ";
        check_output("hello_lit", window, lit);
        held = window;
        ticks_seen = 0;
        for (int i = 0; i < 100; i++) begin
            char_valid = 1'($urandom_range(0, 1));
            char_in    = 8'($urandom_range(33, 126));
            step();
            if (scroll_tick) ticks_seen++;
        end
        char_valid = 1'b0;
        check_output("hello_noticks", 128'(ticks_seen), 128'(0));
        check_output("hello_static", window, held);
        check_output("hello_len_hold", 128'(msg_len), 128'(5));

        // Scrolling through a full wrap
        n = set_text("ABCDEFGHIJKLMNOPQRST");
        apply_stimulus(n, 1'b0, 1'b0);
        fill_and_check("abc");
        scroll_check("abc", 24);

        // Freeze delays the next tick by the frozen cycle count
        freeze = 1'b1;
        ticks_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (scroll_tick) ticks_seen++;
        end
        freeze = 1'b0;
        wait_tick(c);
        check_output("freeze_noticks", 128'(ticks_seen), 128'(0));
        check_output("freeze_delay", 128'(10 + c), 128'(10 + STEP));
        check_output("freeze_win", window, exp_window(1));

        // Reload mid-scroll; same-cycle char_valid is ignored
        load_start = 1'b1;
        char_valid = 1'b1;
        char_in    = "Z";
        load_done  = 1'b0;
        step();
        load_start = 1'b0;
        char_valid = 1'b0;
        check_output("reload_window", window, BLANK);
        check_output("reload_busy", 128'(busy), 128'(1));
        check_output("reload_len", 128'(msg_len), 128'(0));

        // Random long message, gappy capture, random same-cycle done
        n = set_random($urandom_range(17, 50));
        apply_stimulus(n, 1'($urandom_range(0, 1)), 1'b1);
        fill_and_check("rand_long");
        scroll_check("rand_long", n + GAP + 3);

        // Overflow: characters past the buffer never appear
        n = set_random(70);
        apply_stimulus(n, 1'b0, 1'b0);
        fill_and_check("ovf");
        scroll_check("ovf", DEPTH + GAP + 1);

        // Empty message returns to IDLE
        apply_stimulus(0, 1'b0, 1'b0);
        check_output("empty_busy", 128'(busy), 128'(0));
        check_output("empty_window", window, BLANK);
        check_output("empty_len", 128'(msg_len), 128'(0));
        repeat (5) step();
        check_output("empty_idle", 128'(busy), 128'(0));

        // Single character captured in the same cycle as done
        n = set_text("Q");
        apply_stimulus(n, 1'b1, 1'b0);
        fill_and_check("same1");

        // Random short message, last char with done
        n = set_random($urandom_range(2, 16));
        apply_stimulus(n, 1'b1, 1'b1);
        fill_and_check("rand_short");

        // Asynchronous reset in the middle of FILL
        n = set_random(20);
        apply_stimulus(n, 1'b0, 1'b0);
        repeat (5) step();
        #2 reset_n = 1'b0;
        #1;
        check_output("areset_window", window, BLANK);
        check_output("areset_len", 128'(msg_len), 128'(0));
        check_output("areset_busy", 128'(busy), 128'(0));
        check_output("areset_ovf", 128'(overflow), 128'(0));
        check_output("areset_tick", 128'(scroll_tick), 128'(0));
        #2 reset_n = 1'b1;
        ticks_seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (scroll_tick || busy) ticks_seen++;
        end
        check_output("post_reset_idle", 128'(ticks_seen), 128'(0));
        check_output("post_reset_window", window, BLANK);
        check_output("post_reset_len", 128'(msg_len), 128'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
